// File: rtl/ysyx_24110006_csr_pkg.sv
// ysyx_24110006 CSR file: shared op encoding, CSR addresses,
// mstatus/mie/mip bit positions and trap cause codes.
package ysyx_24110006_csr_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_CSRRW = 3'd1,
      OP_CSRRS = 3'd2,
      OP_CSRRC = 3'd3,
      OP_ECALL = 3'd4,
      OP_MRET  = 3'd5,
      OP_IRQ   = 3'd6
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIE_MTIE       = 7;
   localparam int MIP_MTIP       = 7;

   localparam logic [31:0] CAUSE_ECALL_M = 32'd11;
   localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;

   // vectored entry lands at base + 4 * cause (timer cause = 7)
   localparam int IRQ_VEC_OFFSET = 28;

endpackage

// File: rtl/ysyx_24110006_csr_if.sv
// ysyx_24110006 CSR file: request/response bundle between the
// core (master) and the CSR file (slave).
interface ysyx_24110006_csr_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [2:0]      i_op;
   logic [11:0]     i_csr;
   logic [XLEN-1:0] i_wdata;
   logic [XLEN-1:0] i_pc;
   logic            i_mtip;
   logic            o_rvalid;
   logic [XLEN-1:0] o_rdata;
   logic            o_illegal;
   logic            o_redirect;
   logic [XLEN-1:0] o_upc;
   logic            o_irq_pending;

   modport master (
      output i_valid, i_op, i_csr, i_wdata, i_pc, i_mtip,
      input  o_ready, o_rvalid, o_rdata, o_illegal,
      input  o_redirect, o_upc, o_irq_pending
   );

   modport slave (
      input  i_valid, i_op, i_csr, i_wdata, i_pc, i_mtip,
      output o_ready, o_rvalid, o_rdata, o_illegal,
      output o_redirect, o_upc, o_irq_pending
   );
endinterface

// File: rtl/ysyx_24110006_csr_counter.sv
// ysyx_24110006 CSR file: 64-bit free-running cycle counter.
// A half write replaces that half and skips the increment.
module ysyx_24110006_csr_counter (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_we,
   input  logic        i_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_count
);
   logic [63:0] count_q, count_d;

   // next count: software write wins over increment
   always_comb begin
      count_d = count_q + 64'd1;
      if (i_we) begin
         if (i_hi) count_d = {i_wdata, count_q[31:0]};
         else      count_d = {count_q[63:32], i_wdata};
      end
   end

   // counter register
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) count_q <= '0;
      else          count_q <= count_d;
   end

   assign o_count = count_q;
endmodule

// File: rtl/ysyx_24110006_csr_file.sv
// ysyx_24110006 CSR file: M-mode CSRs, ECALL/MRET/timer trap flow.
// Optional mcycle/cycle counter under YSYX_24110006_CSR_MCYCLE_EN.
module ysyx_24110006_csr_file
   import ysyx_24110006_csr_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int MTVEC_VECTORED = 1
) (
   input logic                i_clock,
   input logic                i_reset,
   ysyx_24110006_csr_if.slave bus
);
   localparam logic [XLEN-1:0] MTVEC_MASK =
      (MTVEC_VECTORED != 0) ? ~XLEN'(2) : ~XLEN'(3);

   logic            st_mie_q, st_mie_d;
   logic            st_mpie_q, st_mpie_d;
   logic            mtie_q, mtie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;

   logic            rvalid_q, rvalid_d;
   logic            illegal_q, illegal_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic [XLEN-1:0] upc_q, upc_d;

   logic            ready;
   logic            accept;
   logic            irq_pending;
   logic            hit;
   logic            ro;
   logic            does_write;
   logic [XLEN-1:0] rd_val;
   logic [XLEN-1:0] wval;
   logic [XLEN-1:0] mstatus_rd;
   logic [XLEN-1:0] mie_rd;
   logic [XLEN-1:0] mip_rd;
   logic [XLEN-1:0] trap_base;

`ifdef YSYX_24110006_CSR_MCYCLE_EN
   logic [63:0] count;
   logic        cnt_we;
   logic        cnt_hi;

   ysyx_24110006_csr_counter u_counter (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_we    (cnt_we),
      .i_hi    (cnt_hi),
      .i_wdata (wval),
      .o_count (count)
   );
`endif

   assign ready       = ~redirect_q;
   assign accept      = bus.i_valid & ready;
   assign irq_pending = st_mie_q & mtie_q & bus.i_mtip;
   assign trap_base   = mtvec_q & ~XLEN'(3);
   assign does_write  = (bus.i_op == OP_CSRRW) | (|bus.i_wdata);

   // architectural views of the sparse registers
   always_comb begin
      mstatus_rd = '0;
      mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_rd[MSTATUS_MIE]  = st_mie_q;
      mstatus_rd[MSTATUS_MPIE] = st_mpie_q;
      mie_rd = '0;
      mie_rd[MIE_MTIE] = mtie_q;
      mip_rd = '0;
      mip_rd[MIP_MTIP] = bus.i_mtip;
   end

   // address decode: read value, hit and read-only flags
   always_comb begin
      rd_val = '0;
      hit    = 1'b1;
      ro     = 1'b0;
      unique case (bus.i_csr)
         CSR_MSTATUS:  rd_val = mstatus_rd;
         CSR_MIE:      rd_val = mie_rd;
         CSR_MTVEC:    rd_val = mtvec_q;
         CSR_MSCRATCH: rd_val = mscratch_q;
         CSR_MEPC:     rd_val = mepc_q;
         CSR_MCAUSE:   rd_val = mcause_q;
         CSR_MIP:      rd_val = mip_rd;
         CSR_MVENDORID,
         CSR_MARCHID:  ro = 1'b1;
`ifdef YSYX_24110006_CSR_MCYCLE_EN
         CSR_MCYCLE:   rd_val = count[31:0];
         CSR_MCYCLEH:  rd_val = count[63:32];
         CSR_CYCLE: begin
            rd_val = count[31:0];
            ro     = 1'b1;
         end
         CSR_CYCLEH: begin
            rd_val = count[63:32];
            ro     = 1'b1;
         end
`endif
         default:      hit = 1'b0;
      endcase
   end

   // read-modify-write value for the CSR instructions
   always_comb begin
      unique case (bus.i_op)
         OP_CSRRS: wval = rd_val | bus.i_wdata;
         OP_CSRRC: wval = rd_val & ~bus.i_wdata;
         default:  wval = bus.i_wdata;
      endcase
   end

   // next state for CSRs and the registered response
   always_comb begin
      st_mie_d   = st_mie_q;
      st_mpie_d  = st_mpie_q;
      mtie_d     = mtie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      rvalid_d   = accept;
      illegal_d  = 1'b0;
      redirect_d = 1'b0;
      rdata_d    = '0;
      upc_d      = '0;
`ifdef YSYX_24110006_CSR_MCYCLE_EN
      cnt_we     = 1'b0;
      cnt_hi     = 1'b0;
`endif
      if (accept) begin
         unique case (bus.i_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
               if (!hit || (ro && does_write)) begin
                  illegal_d = 1'b1;
               end else begin
                  rdata_d = rd_val;
                  if (does_write) begin
                     unique case (bus.i_csr)
                        CSR_MSTATUS: begin
                           st_mie_d  = wval[MSTATUS_MIE];
                           st_mpie_d = wval[MSTATUS_MPIE];
                        end
                        CSR_MIE:      mtie_d = wval[MIE_MTIE];
                        CSR_MTVEC:    mtvec_d = wval & MTVEC_MASK;
                        CSR_MSCRATCH: mscratch_d = wval;
                        CSR_MEPC:     mepc_d = wval & ~XLEN'(3);
                        CSR_MCAUSE:   mcause_d = wval;
`ifdef YSYX_24110006_CSR_MCYCLE_EN
                        CSR_MCYCLE:   cnt_we = 1'b1;
                        CSR_MCYCLEH: begin
                           cnt_we = 1'b1;
                           cnt_hi = 1'b1;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            OP_ECALL: begin
               mepc_d     = bus.i_pc & ~XLEN'(3);
               mcause_d   = CAUSE_ECALL_M;
               st_mpie_d  = st_mie_q;
               st_mie_d   = 1'b0;
               redirect_d = 1'b1;
               upc_d      = trap_base;
            end
            OP_MRET: begin
               st_mie_d   = st_mpie_q;
               st_mpie_d  = 1'b1;
               redirect_d = 1'b1;
               upc_d      = mepc_q;
            end
            OP_IRQ: begin
               if (irq_pending) begin
                  mepc_d     = bus.i_pc & ~XLEN'(3);
                  mcause_d   = CAUSE_MTI;
                  st_mpie_d  = st_mie_q;
                  st_mie_d   = 1'b0;
                  redirect_d = 1'b1;
                  upc_d      = mtvec_q[0]
                             ? trap_base + XLEN'(IRQ_VEC_OFFSET)
                             : trap_base;
               end else begin
                  illegal_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // CSR and response registers
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         st_mie_q   <= 1'b0;
         st_mpie_q  <= 1'b0;
         mtie_q     <= 1'b0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         rvalid_q   <= 1'b0;
         illegal_q  <= 1'b0;
         redirect_q <= 1'b0;
         rdata_q    <= '0;
         upc_q      <= '0;
      end else begin
         st_mie_q   <= st_mie_d;
         st_mpie_q  <= st_mpie_d;
         mtie_q     <= mtie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         rvalid_q   <= rvalid_d;
         illegal_q  <= illegal_d;
         redirect_q <= redirect_d;
         rdata_q    <= rdata_d;
         upc_q      <= upc_d;
      end
   end

   assign bus.o_ready       = ready;
   assign bus.o_rvalid      = rvalid_q;
   assign bus.o_rdata       = rdata_q;
   assign bus.o_illegal     = illegal_q;
   assign bus.o_redirect    = redirect_q;
   assign bus.o_upc         = upc_q;
   assign bus.o_irq_pending = irq_pending;
endmodule

// File: tb/tb_ysyx_24110006_csr_file.sv
// ysyx_24110006 CSR file bench: vector table + response scoreboard,
// with hand sequences for reset-during-response and the counter.
module tb_ysyx_24110006_csr_file;
   import ysyx_24110006_csr_pkg::*;

   typedef struct {
      int          id;
      logic [2:0]  op;
      logic [11:0] csr;
      logic [31:0] wdata;
      logic [31:0] pc;
      logic        mtip;
      logic [31:0] rdata;
      logic        chk_rdata;
      logic        illegal;
      logic        redirect;
      logic [31:0] upc;
      logic        irq;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   vec_t exp_q[$];
   vec_t tab[$];

   ysyx_24110006_csr_if #(.XLEN(32)) bus ();

   ysyx_24110006_csr_file #(
      .XLEN(32),
      .MTVEC_VECTORED(1)
   ) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op,
                               input logic [11:0] csr,
                               input logic [31:0] wdata,
                               input logic [31:0] pc,
                               input logic mtip,
                               input logic [31:0] rdata,
                               input logic illegal,
                               input logic redirect,
                               input logic [31:0] upc,
                               input logic irq);
      vec_t v;
      v.id = 0;
      v.op = op;
      v.csr = csr;
      v.wdata = wdata;
      v.pc = pc;
      v.mtip = mtip;
      v.rdata = rdata;
      v.chk_rdata = 1'b1;
      v.illegal = illegal;
      v.redirect = redirect;
      v.upc = upc;
      v.irq = irq;
      return v;
   endfunction

   task automatic send(input vec_t v);
      int n;
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = v.op;
      bus.i_csr   = v.csr;
      bus.i_wdata = v.wdata;
      bus.i_pc    = v.pc;
      bus.i_mtip  = v.mtip;
      n = 0;
      while (!bus.o_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready)
         chk($sformatf("v%0d_ready_wait", v.id), 32'(bus.o_ready), 32'd1);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_op    = 3'd0;
   endtask

   // response monitor, sampling 1 time unit after the edge
   always @(posedge clk) begin
      vec_t e;
      #1;
      if (mon_en) begin
         if (bus.o_rvalid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rvalid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.chk_rdata)
                  chk($sformatf("v%0d_rdata", e.id), bus.o_rdata, e.rdata);
               chk($sformatf("v%0d_illegal", e.id),
                   32'(bus.o_illegal), 32'(e.illegal));
               chk($sformatf("v%0d_redirect", e.id),
                   32'(bus.o_redirect), 32'(e.redirect));
               if (e.redirect)
                  chk($sformatf("v%0d_upc", e.id), bus.o_upc, e.upc);
               chk($sformatf("v%0d_ready", e.id),
                   32'(bus.o_ready), 32'(!e.redirect));
               chk($sformatf("v%0d_irq_pending", e.id),
                   32'(bus.o_irq_pending), 32'(e.irq));
            end
         end else if (bus.o_redirect || bus.o_illegal) begin
            chk("idle_flags", {30'd0, bus.o_redirect, bus.o_illegal}, 32'd0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      bus.i_valid = 1'b0;
      bus.i_op    = 3'd0;
      bus.i_csr   = 12'd0;
      bus.i_wdata = 32'd0;
      bus.i_pc    = 32'd0;
      bus.i_mtip  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
      chk("rst_redirect", 32'(bus.o_redirect), 32'd0);
      chk("rst_illegal", 32'(bus.o_illegal), 32'd0);
      chk("rst_rdata", bus.o_rdata, 32'd0);
      chk("rst_upc", bus.o_upc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      mon_en = 1'b1;

      //           op        csr      wdata         pc            mt rdata        il rd upc           irq
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h0,        32'h0,        0, 32'h0000_1800, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h305, 32'h0,        32'h0,        0, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h340, 32'hDEADBEEF, 32'h0,        0, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h340, 32'h1,        32'h0,        0, 32'hDEADBEEF,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRC, 12'h340, 32'hF,        32'h0,        0, 32'hDEADBEEF,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h340, 32'h0,        32'h0,        0, 32'hDEADBEE0,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h7C0, 32'h5,        32'h0,        0, 32'h0,         1, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'hF11, 32'h5,        32'h0,        0, 32'h0,         1, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'hF11, 32'h0,        32'h0,        0, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h305, 32'h80000100, 32'h0,        0, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h8,        32'h0,        0, 32'h0000_1800, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_ECALL, 12'h0,   32'h0,        32'h80000040, 0, 32'h0,         0, 1, 32'h80000100, 0));
      tab.push_back(mk(OP_CSRRS, 12'h341, 32'h0,        32'h0,        0, 32'h80000040,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h342, 32'h0,        32'h0,        0, 32'd11,        0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h0,        32'h0,        0, 32'h0000_1880, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_MRET,  12'h0,   32'h0,        32'h0,        0, 32'h0,         0, 1, 32'h80000040, 0));
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h0,        32'h0,        0, 32'h0000_1888, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h341, 32'h12345677, 32'h0,        0, 32'h80000040,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h341, 32'h0,        32'h0,        0, 32'h12345674,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_IRQ,   12'h0,   32'h0,        32'h80000300, 0, 32'h0,         1, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h305, 32'h80000101, 32'h0,        0, 32'h80000100,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h304, 32'h80,       32'h0,        0, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h344, 32'h0,        32'h0,        1, 32'h80,        0, 0, 32'h0,        1));
      tab.push_back(mk(OP_IRQ,   12'h0,   32'h0,        32'h80000200, 1, 32'h0,         0, 1, 32'h8000011C, 0));
      tab.push_back(mk(OP_CSRRS, 12'h342, 32'h0,        32'h0,        1, 32'h80000007,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h341, 32'h0,        32'h0,        1, 32'h80000200,  0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h0,        32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRC, 12'h304, 32'h80,       32'h0,        1, 32'h80,        0, 0, 32'h0,        0));
      tab.push_back(mk(OP_NONE,  12'h300, 32'h0,        32'h0,        1, 32'h0,         0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'hF12, 32'h0,        32'h0,        1, 32'h0,         1, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h344, 32'h5,        32'h0,        1, 32'h80,        0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRW, 12'h300, 32'hFFFFFFFF, 32'h0,        1, 32'h0000_1880, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h300, 32'h0,        32'h0,        1, 32'h0000_1888, 0, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'h304, 32'h0,        32'h0,        1, 32'h0,         0, 0, 32'h0,        0));
`ifndef YSYX_24110006_CSR_MCYCLE_EN
      tab.push_back(mk(OP_CSRRS, 12'hB00, 32'h0,        32'h0,        1, 32'h0,         1, 0, 32'h0,        0));
      tab.push_back(mk(OP_CSRRS, 12'hC80, 32'h0,        32'h0,        1, 32'h0,         1, 0, 32'h0,        0));
`endif

      for (int i = 0; i < tab.size(); i++) begin
         v = tab[i];
         v.id = i;
         send(v);
      end
      repeat (3) @(posedge clk);

      // reset lands in the cycle that carries an ECALL response
      mon_en = 1'b0;
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = OP_ECALL;
      bus.i_pc    = 32'h80000040;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      bus.i_op    = 3'd0;
      chk("b_redirect_before_rst", 32'(bus.o_redirect), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("b_redirect_in_rst", 32'(bus.o_redirect), 32'd0);
      chk("b_rvalid_in_rst", 32'(bus.o_rvalid), 32'd0);
      chk("b_upc_in_rst", bus.o_upc, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      mon_en = 1'b1;
      v = mk(OP_CSRRS, 12'h341, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0);
      v.id = 100;
      send(v);
      v = mk(OP_CSRRS, 12'h300, 32'h0, 32'h0, 1, 32'h1800, 0, 0, 32'h0, 0);
      v.id = 101;
      send(v);
      v = mk(OP_CSRRS, 12'h342, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0);
      v.id = 102;
      send(v);

`ifdef YSYX_24110006_CSR_MCYCLE_EN
      v = mk(OP_CSRRW, 12'hB00, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0);
      v.id = 200;
      v.chk_rdata = 1'b0;
      send(v);
      @(posedge clk);
      v = mk(OP_CSRRS, 12'hB80, 32'h0, 32'h0, 1, 32'h1, 0, 0, 32'h0, 0);
      v.id = 201;
      send(v);
      v = mk(OP_CSRRW, 12'hC00, 32'h0, 32'h0, 1, 32'h0, 1, 0, 32'h0, 0);
      v.id = 202;
      send(v);
      v = mk(OP_CSRRS, 12'hC80, 32'h0, 32'h0, 1, 32'h1, 0, 0, 32'h0, 0);
      v.id = 203;
      send(v);
`endif

      repeat (3) @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ysyx_24110006_csr_file.md
YSYX_24110006_CSR_FILE -- requirements
Module: ysyx_24110006_csr_file

Interface
REQ-001 Parameter XLEN, default 32, data width of CSRs, i_wdata, i_pc, o_rdata, o_upc; only 32 supported.
REQ-002 Parameter MTVEC_VECTORED, default 1, when 1 mtvec.MODE=1 selects vectored interrupt entry; when 0 MODE bits read 0 and writes to them are ignored.
REQ-003 i_clock  in  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_valid  in  1  request valid; o_ready  out  1  request accepted when both are high at an edge.
REQ-006 i_op  in  3  NONE=0, CSRRW=1, CSRRS=2, CSRRC=3, ECALL=4, MRET=5, IRQ=6.
REQ-007 i_csr  in  12  CSR address; i_wdata  in  XLEN  write data or set/clear mask; i_pc  in  XLEN  PC of the requesting instruction.
REQ-008 i_mtip  in  1  machine timer interrupt level, already synchronous.
REQ-009 o_rvalid  out  1  response valid; o_rdata  out  XLEN  old CSR value; o_illegal  out  1  illegal access.
REQ-010 o_redirect  out  1  PC redirect; o_upc  out  XLEN  redirect target; o_irq_pending  out  1  interrupt takeable.

Function
REQ-011 Implemented CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP bits 12:11 hardwired 2'b11), mie 0x304 (MTIE bit 7 only), mtvec 0x305, mscratch 0x340, mepc 0x341 (bits 1:0 read 0), mcause 0x342, mip 0x344 (MTIP bit 7 read-only, mirrors i_mtip), mvendorid 0xF11 and marchid 0xF12 (read-only, read 0).
REQ-012 Accepted request at edge N: o_rvalid=1 for exactly cycle N+1; o_rdata holds the pre-write value; the CSR update takes effect at edge N.
REQ-013 CSRRW writes i_wdata; CSRRS writes old|i_wdata; CSRRC writes old&~i_wdata; CSRRS/CSRRC with i_wdata==0 perform no write.
REQ-014 Unimplemented address, or a write-performing op to a read-only CSR: o_illegal=1 and o_rdata=0 in cycle N+1, no state change.
REQ-015 ECALL: mepc<=i_pc, mcause<=11, MPIE<=MIE, MIE<=0; in cycle N+1 o_redirect=1 and o_upc=mtvec base (mtvec & ~3).
REQ-016 MRET: MIE<=MPIE, MPIE<=1; o_redirect=1 and o_upc=mepc in cycle N+1.
REQ-017 o_irq_pending = MIE & MTIE & MTIP (combinational); IRQ op: trap entry as ECALL but mcause<=0x8000_0007; o_upc = base+28 when MODE=1, else base.
REQ-018 An IRQ op while o_irq_pending=0 is illegal (o_illegal=1, no state change, no redirect).
REQ-019 o_ready=0 for the cycle in which o_redirect=1 (flush bubble); o_ready=1 otherwise.
REQ-020 NONE op accepted: o_rvalid=1 and o_rdata=0 in cycle N+1, no state change.
REQ-021 o_rvalid, o_redirect, o_illegal are 0 in every cycle not following an accepted request.

Reset
REQ-022 Asserted reset clears all CSRs to 0 except mstatus=0x0000_1800; o_rvalid, o_redirect, o_illegal, o_rdata, o_upc are 0.
REQ-023 o_ready=1 from the first edge after reset release; a response pending when reset asserts is dropped.

Configuration
REQ-024 Macro YSYX_24110006_CSR_MCYCLE_EN defined: 64-bit mcycle at 0xB00 (low) / 0xB80 (high), read-only aliases cycle 0xC00 / cycleh 0xC80, incrementing by 1 every cycle, wrapping at 2^64.
REQ-025 A write to mcycle/mcycleh replaces that half and suppresses the increment in that cycle; the other half holds.
REQ-026 Macro not defined: 0xB00, 0xB80, 0xC00, 0xC80 are unimplemented (REQ-014) and no counter logic exists.

Structure
REQ-027 Package ysyx_24110006_csr_pkg holds the op encoding, CSR addresses, mstatus/mie/mip bit positions, and cause codes.
REQ-028 The 64-bit counter is sub-module ysyx_24110006_csr_counter (inputs: write enable, half select, data; output: count), instantiated only under the macro.

Verification
REQ-029 CSRRW 0x340 with 0xDEADBEEF, then CSRRS 0x340 with 0x0000_0001 -> second response o_rdata=0xDEADBEEF, mscratch=0xDEADBEEF.
REQ-030 mtvec=0x8000_0100, MIE=1, ECALL at pc 0x8000_0040 -> o_upc=0x8000_0100, mepc=0x8000_0040, mcause=11, mstatus=0x1880, o_ready=0 for one cycle; MRET -> o_upc=0x8000_0040, mstatus=0x1888.
REQ-031 mtvec=0x8000_0101, MIE=1, MTIE=1, i_mtip=1 -> o_irq_pending=1; IRQ op -> o_upc=0x8000_011C, mcause=0x8000_0007.
REQ-032 CSRRW 0x7C0, and CSRRW 0xF11 -> o_illegal=1, o_rdata=0, no state change; CSRRS 0xF11 with 0 -> legal, o_rdata=0.
REQ-033 With macro: CSRRW 0xB00 with 0xFFFF_FFFF, idle 1 cycle -> read 0xB80 returns 1; without macro -> read 0xB00 gives o_illegal=1.
REQ-034 Reset asserted in cycle following an accepted ECALL -> o_redirect=0, mepc=0, mstatus=0x1800.
